mem_loader: RTL and testbench
=============================

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 217, clk25 cycles per serial bit (115200 baud at 25 MHz).
REQ-002 SHALL have parameter TIMEOUT, default 1048576, clk25 cycles allowed between bytes of one command.
REQ-003 SHALL have port clk25  input  1  master 25 MHz clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rx  input  1  serial in, 8N1, idle high, asynchronous to clk25.
REQ-006 SHALL have port tx  output  1  serial out, 8N1, idle high.
REQ-007 SHALL have port bus_req  output  1  request for ownership of the CPU memory bus.
REQ-008 SHALL have port bus_gnt  input  1  bus granted (CPU stalled); accesses only while high.
REQ-009 SHALL have port ab  output  16  bus address.
REQ-010 SHALL have port dbo  output  8  bus write data.
REQ-011 SHALL have port we  output  1  bus write strobe, one clk25 cycle per byte.
REQ-012 SHALL have port dbi  input  8  bus read data, valid on the clk25 edge following address presentation (synchronous RAM/ROM).
REQ-013 SHALL have port busy  output  1  high from command byte accepted until command complete or aborted.

Function
REQ-014 RX SHALL pass rx through a 2-flop synchronizer, detect start on a high-to-low transition, sample each bit at mid-bit (CLK_DIV/2 after edge, then every CLK_DIV), LSB first.
REQ-015 RX byte with stop bit 0 SHALL be discarded (framing error); FSM state unchanged.
REQ-016 TX SHALL send start(0), 8 data LSB first, stop(1), each CLK_DIV cycles; a new byte is accepted only when TX idle.
REQ-017 FSM states: IDLE, ADDR_HI, ADDR_LO, LEN, WDATA, WBUS, RBUS, RWAIT, RSEND, REPLY.
REQ-018 IDLE: byte 0x57 ('W') or 0x52 ('R') -> ADDR_HI, busy=1; any other byte -> transmit 0x3F ('?'), stay IDLE.
REQ-019 ADDR_HI/ADDR_LO/LEN SHALL capture address high, address low, length; length 0x00 means 256 bytes.
REQ-020 bus_req SHALL assert on entry to WDATA or RBUS and deassert on entry to REPLY or IDLE.
REQ-021 Write: each data byte received in WDATA -> WBUS; first cycle with bus_gnt=1 drives ab=addr, dbo=byte, we=1 for exactly one cycle; addr+1, count-1; count 0 -> REPLY with 0x2E ('.'), else WDATA.
REQ-022 Data byte received while in WBUS (grant not yet given) SHALL abort: we never pulsed for that byte, transmit 0x21 ('!'), -> REPLY.
REQ-023 Read: RBUS waits for bus_gnt=1, drives ab=addr with we=0; RWAIT captures dbi next cycle; RSEND transmits byte when TX idle, addr+1, count-1; count 0 -> IDLE after last byte fully sent, else RBUS.
REQ-024 Address SHALL wrap 0xFFFF -> 0x0000 (16-bit modulo); count is 9-bit.
REQ-025 In ADDR_HI, ADDR_LO, LEN, WDATA: TIMEOUT cycles with no RX byte -> abort, transmit 0x21, bus_req=0, -> REPLY.
REQ-026 REPLY SHALL return to IDLE and drop busy once reply byte's stop bit completes; RX bytes received in REPLY are discarded.
REQ-027 bus_gnt deasserted mid-command SHALL only stall; ab/dbo/we SHALL be 0 while bus_gnt=0.

Reset
REQ-028 rst_n=0 at a clk25 edge SHALL force: tx=1, bus_req=0, we=0, ab=0x0000, dbo=0x00, busy=0, FSM IDLE, RX/TX idle, counters 0.
REQ-029 Reset mid-byte or mid-command SHALL abandon it with no further we pulse and no partial TX byte after release.

Verification
REQ-030 'W',0x02,0x00,0x03,0xA9,0x01,0x60 with bus_gnt tied 1 -> we pulses at ab 0x0200/0x0201/0x0202 with dbo 0xA9/0x01/0x60, then tx 0x2E, busy=0.
REQ-031 'R',0xFF,0xFF,0x02, memory model 0xFFFF=0x12, 0x0000=0x34 -> ab 0xFFFF then 0x0000 (wrap), tx 0x12 then 0x34, no we.
REQ-032 Byte 0x41 in IDLE -> tx 0x3F, bus_req stays 0, busy stays 0.
REQ-033 'W',0x10,0x00,0x00 then 256 bytes, bus_gnt delayed 5 cycles per request -> 256 we pulses 0x1000..0x10FF, then 0x2E.
REQ-034 'W',0x00,0x00,0x02,0x55 then silence TIMEOUT cycles -> one we pulse, tx 0x21, bus_req=0, IDLE; framing-error byte mid-stream ignored.
REQ-035 rst_n low during 'R' transmission of second byte -> tx=1 at once, bus_req=0, no further bus activity; next 'R' command works normally.

Source files
------------

// File: rtl/mem_loader_if.sv
// CPU memory bus as seen by the serial loader: request/grant handshake plus
// address, write data, write strobe and synchronous read data.
interface mem_loader_if;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] ab;
  logic [7:0]  dbo;
  logic        we;
  logic [7:0]  dbi;

  modport master (output bus_req, ab, dbo, we, input bus_gnt, dbi);
  modport slave  (input bus_req, ab, dbo, we, output bus_gnt, dbi);
endinterface

// File: rtl/mem_loader.sv
// UART-driven memory loader: 'W'/'R' commands with 16-bit address and length
// write to or read back from the CPU memory bus while the CPU is held off.
module mem_loader #(
  parameter int CLK_DIV = 217,
  parameter int TIMEOUT = 1048576
) (
  input  logic         clk25,
  input  logic         rst_n,
  input  logic         rx,
  output logic         tx,
  output logic         busy,
  mem_loader_if.master bus
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR_HI, ADDR_LO, LEN, WDATA, WBUS, RBUS, RWAIT, RSEND, REPLY
  } state_t;

  // ---------------- UART receiver ----------------
  logic          rx_s1, rx_s2, rx_prev;
  logic          rx_act, rx_vld;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_sh;

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      rx_act  <= 1'b0;
      rx_vld  <= 1'b0;
      rx_cnt  <= '0;
      rx_bit  <= '0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_vld  <= 1'b0;
      if (!rx_act) begin
        if (rx_prev && !rx_s2) begin
          rx_act <= 1'b1;
          rx_cnt <= HALF_BIT;
          rx_bit <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - CW'(1);
      end else begin
        rx_cnt <= FULL_BIT;
        rx_bit <= rx_bit + 4'd1;
        // A start bit that is high again at mid-bit was a glitch.
        if (rx_bit == 4'd0) begin
          if (rx_s2) rx_act <= 1'b0;
        end else if (rx_bit == 4'd9) begin
          rx_act <= 1'b0;
          rx_vld <= rx_s2;
        end
      end
    end
  end

  always_ff @(posedge clk25) begin
    if (rx_act && rx_cnt == '0 && rx_bit != 4'd0 && rx_bit != 4'd9)
      rx_sh <= {rx_s2, rx_sh[7:1]};
  end

  // ---------------- UART transmitter ----------------
  logic          tx_act, tx_go;
  logic [7:0]    tx_byte;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [9:0]    tx_sh;

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      tx_act <= 1'b0;
      tx_cnt <= '0;
      tx_bit <= '0;
    end else if (!tx_act) begin
      if (tx_go) begin
        tx_act <= 1'b1;
        tx_cnt <= FULL_BIT;
        tx_bit <= '0;
      end
    end else if (tx_cnt != '0) begin
      tx_cnt <= tx_cnt - CW'(1);
    end else if (tx_bit == 4'd9) begin
      tx_act <= 1'b0;
    end else begin
      tx_cnt <= FULL_BIT;
      tx_bit <= tx_bit + 4'd1;
    end
  end

  always_ff @(posedge clk25) begin
    if (!tx_act && tx_go)
      tx_sh <= {1'b1, tx_byte, 1'b0};
    else if (tx_act && tx_cnt == '0)
      tx_sh <= {1'b1, tx_sh[9:1]};
  end

  assign tx = !tx_act || tx_sh[0];

  // ---------------- command FSM ----------------
  state_t        state, state_n;
  logic          is_rd, is_rd_n;
  logic [15:0]   addr, addr_n;
  logic [8:0]    cnt, cnt_n;
  logic [7:0]    wbyte, wbyte_n, rdata, rdata_n, reply, reply_n;
  logic          rpend, rpend_n;
  logic [TW-1:0] tmo;
  logic          timed, tmo_hit, abort, we_c, drive_r, bus_req_q;

  assign timed   = (state inside {ADDR_HI, ADDR_LO, LEN, WDATA});
  assign tmo_hit = timed && (tmo == TMO_LAST);

  always_comb begin
    state_n = state;
    is_rd_n = is_rd;
    addr_n  = addr;
    cnt_n   = cnt;
    wbyte_n = wbyte;
    rdata_n = rdata;
    reply_n = reply;
    rpend_n = rpend;
    tx_go   = 1'b0;
    tx_byte = 8'h00;
    we_c    = 1'b0;
    drive_r = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE: if (rx_vld) begin
        if (rx_sh == 8'h57 || rx_sh == 8'h52) begin
          state_n = ADDR_HI;
          is_rd_n = (rx_sh == 8'h52);
        end else if (!tx_act) begin
          tx_go   = 1'b1;
          tx_byte = 8'h3F;
        end
      end
      ADDR_HI: if (rx_vld) begin
        addr_n[15:8] = rx_sh;
        state_n      = ADDR_LO;
      end else if (tmo_hit) abort = 1'b1;
      ADDR_LO: if (rx_vld) begin
        addr_n[7:0] = rx_sh;
        state_n     = LEN;
      end else if (tmo_hit) abort = 1'b1;
      LEN: if (rx_vld) begin
        cnt_n   = {(rx_sh == 8'h00), rx_sh};
        state_n = is_rd ? RBUS : WDATA;
      end else if (tmo_hit) abort = 1'b1;
      WDATA: if (rx_vld) begin
        wbyte_n = rx_sh;
        state_n = WBUS;
      end else if (tmo_hit) abort = 1'b1;
      // A new byte arriving before the grant means data would be lost.
      WBUS: if (rx_vld) begin
        abort = 1'b1;
      end else if (bus.bus_gnt) begin
        we_c   = 1'b1;
        addr_n = addr + 16'd1;
        cnt_n  = cnt - 9'd1;
        if (cnt == 9'd1) begin
          state_n = REPLY;
          reply_n = 8'h2E;
          rpend_n = 1'b1;
        end else begin
          state_n = WDATA;
        end
      end
      RBUS: if (bus.bus_gnt) begin
        drive_r = 1'b1;
        state_n = RWAIT;
      end
      RWAIT: begin
        rdata_n = bus.dbi;
        state_n = RSEND;
      end
      RSEND: if (!tx_act) begin
        tx_go   = 1'b1;
        tx_byte = rdata;
        addr_n  = addr + 16'd1;
        cnt_n   = cnt - 9'd1;
        state_n = (cnt == 9'd1) ? REPLY : RBUS;
      end
      // Holds until any queued reply byte, or the last read byte, has left.
      REPLY: if (!tx_act) begin
        if (rpend) begin
          tx_go   = 1'b1;
          tx_byte = reply;
          rpend_n = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      state_n = REPLY;
      reply_n = 8'h21;
      rpend_n = 1'b1;
    end
  end

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state     <= IDLE;
      is_rd     <= 1'b0;
      addr      <= '0;
      cnt       <= '0;
      reply     <= '0;
      rpend     <= 1'b0;
      tmo       <= '0;
      bus_req_q <= 1'b0;
    end else begin
      state     <= state_n;
      is_rd     <= is_rd_n;
      addr      <= addr_n;
      cnt       <= cnt_n;
      reply     <= reply_n;
      rpend     <= rpend_n;
      tmo       <= (timed && state_n == state) ? tmo + TW'(1) : '0;
      bus_req_q <= (state_n inside {WDATA, WBUS, RBUS, RWAIT, RSEND});
    end
  end

  always_ff @(posedge clk25) begin
    wbyte <= wbyte_n;
    rdata <= rdata_n;
  end

  assign busy        = (state != IDLE);
  assign bus.bus_req = bus_req_q;
  assign bus.we      = we_c;
  assign bus.ab      = (we_c || drive_r) ? addr : 16'h0000;
  assign bus.dbo     = we_c ? wbyte : 8'h00;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: serial command driver, serial reply decoder,
// synchronous memory model with a programmable grant delay.
module tb_mem_loader;
  localparam int CLK_DIV = 8;
  localparam int TIMEOUT = 400;

  logic clk25 = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  logic tx, busy;

  mem_loader_if mbus ();

  mem_loader #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk25(clk25), .rst_n(rst_n), .rx(rx), .tx(tx), .busy(busy), .bus(mbus)
  );

  always #20 clk25 = ~clk25;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // synchronous memory
  logic [7:0] mem [0:65535];
  always @(posedge clk25) begin
    if (mbus.we) mem[mbus.ab] <= mbus.dbo;
    mbus.dbi <= mem[mbus.ab];
  end

  // bus observers, sampled just after the falling edge
  logic [15:0] wr_ab[$];
  logic [7:0]  wr_db[$];
  int viol = 0, act = 0;
  logic watch = 1'b0, hi_req = 1'b0, hi_busy = 1'b0;
  always @(negedge clk25) begin
    #2;
    if (mbus.we === 1'b1) begin
      wr_ab.push_back(mbus.ab);
      wr_db.push_back(mbus.dbo);
    end
    if (mbus.bus_gnt === 1'b0 && (mbus.we !== 1'b0 || mbus.ab !== 16'h0 || mbus.dbo !== 8'h0)) viol++;
    if (watch && (mbus.we !== 1'b0 || mbus.ab !== 16'h0)) act++;
    if (busy === 1'b1) hi_busy = 1'b1;
    if (mbus.bus_req === 1'b1) hi_req = 1'b1;
  end

  // grant: tied high, or withdrawn after every write and returned 5 cycles later
  logic gnt_dly = 1'b0;
  int gcnt = 0, wn_seen = 0;
  always @(negedge clk25) begin
    if (!gnt_dly) mbus.bus_gnt = 1'b1;
    else if (mbus.bus_req !== 1'b1 || wr_ab.size() != wn_seen) begin
      mbus.bus_gnt = 1'b0;
      gcnt = 0;
    end else if (gcnt < 5) gcnt++;
    else mbus.bus_gnt = 1'b1;
    wn_seen = wr_ab.size();
  end

  // serial reply decoder; frames cut by a reset are dropped
  logic [7:0] rxq[$];
  int rst_epoch = 0;
  always @(negedge clk25) if (!rst_n) rst_epoch++;
  always begin
    @(negedge clk25);
    if (tx === 1'b0 && rst_n) begin
      automatic int ep = rst_epoch;
      automatic logic [7:0] b = 8'h00;
      repeat (CLK_DIV / 2) @(negedge clk25);
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) @(negedge clk25);
        b[i] = tx;
      end
      repeat (CLK_DIV) @(negedge clk25);
      if (tx === 1'b1 && ep == rst_epoch) rxq.push_back(b);
    end
  end

  function automatic logic [7:0] rq(input int i);
    return (i < rxq.size()) ? rxq[i] : 8'hXX;
  endfunction
  function automatic logic [15:0] wa(input int i);
    return (i < wr_ab.size()) ? wr_ab[i] : 16'hDEAD;
  endfunction
  function automatic logic [7:0] wd(input int i);
    return (i < wr_db.size()) ? wr_db[i] : 8'hXX;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    @(negedge clk25);
    rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk25);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLK_DIV) @(negedge clk25);
    end
    rx = stop;
    repeat (CLK_DIV) @(negedge clk25);
    rx = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk25);
  endtask

  task automatic wait_q(input int n, input int budget);
    for (int k = 0; k < budget && rxq.size() < n; k++) @(negedge clk25);
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget && busy !== 1'b0; k++) @(negedge clk25);
  endtask

  task automatic clear_logs();
    rxq.delete();
    wr_ab.delete();
    wr_db.delete();
  endtask

  initial begin
    #8000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(negedge clk25);
    check("rst_tx", tx, 1);
    check("rst_req", mbus.bus_req, 0);
    check("rst_we", mbus.we, 0);
    check("rst_ab", mbus.ab, 16'h0000);
    check("rst_dbo", mbus.dbo, 8'h00);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk25);

    // three-byte write, grant tied high
    send_byte(8'h57);
    check("w_busy", busy, 1);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'hA9); send_byte(8'h01); send_byte(8'h60);
    wait_q(1, 40 * CLK_DIV);
    check("w_n", wr_ab.size(), 3);
    check("w_ab0", wa(0), 16'h0200); check("w_db0", wd(0), 8'hA9);
    check("w_ab1", wa(1), 16'h0201); check("w_db1", wd(1), 8'h01);
    check("w_ab2", wa(2), 16'h0202); check("w_db2", wd(2), 8'h60);
    check("w_reply", rq(0), 8'h2E);
    wait_idle(20 * CLK_DIV);
    check("w_busy_end", busy, 0);
    check("w_req_end", mbus.bus_req, 0);
    check("w_mem", mem[16'h0201], 8'h01);
    clear_logs();

    // two-byte read across the address wrap
    mem[16'hFFFE] = 8'hEE; mem[16'hFFFF] = 8'h12;
    mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h77;
    send_byte(8'h52); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
    wait_q(2, 60 * CLK_DIV);
    check("r_b0", rq(0), 8'h12);
    check("r_b1", rq(1), 8'h34);
    check("r_nowe", wr_ab.size(), 0);
    wait_idle(20 * CLK_DIV);
    check("r_busy_end", busy, 0);
    check("r_req_end", mbus.bus_req, 0);
    clear_logs();

    // unknown command byte
    hi_req = 1'b0; hi_busy = 1'b0;
    send_byte(8'h41);
    wait_q(1, 30 * CLK_DIV);
    check("q_reply", rq(0), 8'h3F);
    check("q_req", hi_req, 0);
    check("q_busy", hi_busy, 0);
    clear_logs();

    // 256-byte write with delayed grant
    gnt_dly = 1'b1;
    send_byte(8'h57); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'(i) ^ 8'h5A);
    wait_q(1, 40 * CLK_DIV);
    check("l_n", wr_ab.size(), 256);
    begin
      automatic int errs = 0;
      for (int i = 0; i < 256; i++)
        if (wa(i) !== 16'h1000 + 16'(i) || wd(i) !== (8'(i) ^ 8'h5A)) errs++;
      check("l_seq", errs, 0);
    end
    check("l_last", wa(255), 16'h10FF);
    check("l_reply", rq(0), 8'h2E);
    wait_idle(20 * CLK_DIV);
    gnt_dly = 1'b0;
    clear_logs();

    // timeout mid-write with a framing-error byte in between
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h55);
    send_byte(8'hFF, 1'b0);
    wait_q(1, TIMEOUT + 40 * CLK_DIV);
    check("t_reply", rq(0), 8'h21);
    check("t_n", wr_ab.size(), 1);
    check("t_ab", wa(0), 16'h0000);
    check("t_db", wd(0), 8'h55);
    wait_idle(20 * CLK_DIV);
    check("t_busy", busy, 0);
    check("t_req", mbus.bus_req, 0);
    clear_logs();

    // reset during second read byte, then a normal read
    mem[16'h0010] = 8'hA1; mem[16'h0011] = 8'hB2;
    mem[16'h0012] = 8'hC3; mem[16'h0013] = 8'hD4;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h10); send_byte(8'h04);
    wait_q(1, 40 * CLK_DIV);
    check("x_b0", rq(0), 8'hA1);
    repeat (4 * CLK_DIV) @(negedge clk25);
    rst_n = 1'b0;
    @(negedge clk25);
    check("x_tx", tx, 1);
    check("x_req", mbus.bus_req, 0);
    check("x_busy", busy, 0);
    @(negedge clk25);
    rst_n = 1'b1;
    act = 0; watch = 1'b1;
    repeat (30 * CLK_DIV) @(negedge clk25);
    watch = 1'b0;
    check("x_nobyte", rxq.size(), 1);
    check("x_nobus", act, 0);
    check("x_nowe", wr_ab.size(), 0);
    clear_logs();
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h12); send_byte(8'h01);
    wait_q(1, 40 * CLK_DIV);
    check("x_again", rq(0), 8'hC3);
    wait_idle(20 * CLK_DIV);
    check("x_idle", busy, 0);

    check("gate", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
